// File: rtl/window_sequencer.sv
// Frames a raw sample stream into fixed-length windows with index/last sideband
// and bounds the number of windows outstanding at the downstream stage.
module window_sequencer #(
    parameter int PAR_DATA_WIDTH   = 16,
    parameter int PAR_WINDOW_LEN   = 128,
    parameter int PAR_USER_WIDTH   = $clog2(PAR_WINDOW_LEN),
    parameter int PAR_MAX_INFLIGHT = 2,
    parameter int PAR_CNT_WIDTH    = 16,
    parameter int PAR_INF_WIDTH    = $clog2(PAR_MAX_INFLIGHT + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic [PAR_CNT_WIDTH-1:0]  i_num_windows,
    input  logic                      s_axis_tvalid,
    input  logic [PAR_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                      s_axis_tready,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [PAR_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [PAR_USER_WIDTH-1:0] m_axis_tuser,
    input  logic                      m_axis_tready,
    input  logic                      i_win_done,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [PAR_CNT_WIDTH-1:0]  o_win_sent,
    output logic [PAR_INF_WIDTH-1:0]  o_inflight,
    output logic                      o_err
);

    localparam logic [PAR_USER_WIDTH-1:0] LP_LAST_IDX = PAR_USER_WIDTH'(PAR_WINDOW_LEN - 1);
    localparam logic [PAR_INF_WIDTH-1:0]  LP_MAX_INF  = PAR_INF_WIDTH'(PAR_MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [PAR_USER_WIDTH-1:0] r_idx;
    logic [PAR_CNT_WIDTH-1:0]  r_num;
    logic [PAR_CNT_WIDTH-1:0]  r_win_sent;
    logic [PAR_INF_WIDTH-1:0]  r_inflight;
    logic [PAR_INF_WIDTH-1:0]  w_inflight_next;
    logic                      r_stop_pend;
    logic                      w_stop_pend_next;
    logic                      r_done;
    logic                      w_done_next;
    logic                      r_err;
    logic                      w_accept_start;
    logic                      w_run;
    logic                      w_beat;
    logic                      w_last_beat;
    logic                      w_dec;
    logic                      w_quota_hit;

    // Zero-latency pass-through; tdata is gated so every output reads 0 outside RUN.
    assign w_run         = (r_state == ST_RUN);
    assign m_axis_tvalid = s_axis_tvalid & w_run;
    assign s_axis_tready = m_axis_tready & w_run;
    assign m_axis_tdata  = w_run ? s_axis_tdata : {PAR_DATA_WIDTH{1'b0}};
    assign m_axis_tuser  = r_idx;
    assign m_axis_tlast  = (r_idx == LP_LAST_IDX);
    assign w_beat        = m_axis_tvalid & m_axis_tready;
    assign w_last_beat   = w_beat & (r_idx == LP_LAST_IDX);
    assign w_dec         = i_win_done & (r_inflight != {PAR_INF_WIDTH{1'b0}});
    assign w_quota_hit   = (r_num != {PAR_CNT_WIDTH{1'b0}}) &&
                           ((r_win_sent + PAR_CNT_WIDTH'(1)) == r_num);

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_win_sent = r_win_sent;
    assign o_inflight = r_inflight;
    assign o_err      = r_err;

    // In-flight count after this cycle's issue and completion.
    always_comb begin
        w_inflight_next = r_inflight;
        case ({w_last_beat, w_dec})
            2'b10:   w_inflight_next = r_inflight + PAR_INF_WIDTH'(1);
            2'b01:   w_inflight_next = r_inflight - PAR_INF_WIDTH'(1);
            default: w_inflight_next = r_inflight;
        endcase
    end

    // Next-state logic; stops are only honoured at window boundaries.
    always_comb begin
        w_state_next     = r_state;
        w_stop_pend_next = r_stop_pend;
        w_done_next      = 1'b0;
        w_accept_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept_start   = 1'b1;
                    w_stop_pend_next = 1'b0;
                    w_state_next     = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last_beat) begin
                    if (w_quota_hit || r_stop_pend || i_stop) begin
                        w_state_next = ST_DRAIN;
                    end else if (w_inflight_next == LP_MAX_INF) begin
                        w_state_next = ST_STALL;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else if (i_stop) begin
                    if ((r_idx == {PAR_USER_WIDTH{1'b0}}) && !w_beat) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_stop_pend_next = 1'b1;
                    end
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_STALL: begin
                if (i_stop) begin
                    w_stop_pend_next = 1'b1;
                end else begin
                    w_stop_pend_next = r_stop_pend;
                end
                if (w_inflight_next < LP_MAX_INF) begin
                    w_state_next = (r_stop_pend || i_stop) ? ST_DRAIN : ST_RUN;
                end else begin
                    w_state_next = ST_STALL;
                end
            end
            ST_DRAIN: begin
                if (w_inflight_next == {PAR_INF_WIDTH{1'b0}}) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Window index, counters, flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx       <= {PAR_USER_WIDTH{1'b0}};
            r_num       <= {PAR_CNT_WIDTH{1'b0}};
            r_win_sent  <= {PAR_CNT_WIDTH{1'b0}};
            r_inflight  <= {PAR_INF_WIDTH{1'b0}};
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_inflight  <= w_inflight_next;
            r_stop_pend <= w_stop_pend_next;
            r_done      <= w_done_next;
            if (i_win_done && (r_inflight == {PAR_INF_WIDTH{1'b0}})) begin
                r_err <= 1'b1;
            end
            if (w_accept_start) begin
                r_num      <= i_num_windows;
                r_idx      <= {PAR_USER_WIDTH{1'b0}};
                r_win_sent <= {PAR_CNT_WIDTH{1'b0}};
            end else if (w_beat) begin
                if (w_last_beat) begin
                    r_idx      <= {PAR_USER_WIDTH{1'b0}};
                    r_win_sent <= r_win_sent + PAR_CNT_WIDTH'(1);
                end else begin
                    r_idx <= r_idx + PAR_USER_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window_sequencer.sv
// Directed self-checking bench for window_sequencer with LEN=8, MAX_INFLIGHT=2.
module tb_window_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] num_windows;
    logic        s_tvalid;
    logic [15:0] s_tdata;
    logic        s_tready;
    logic        m_tvalid;
    logic        m_tlast;
    logic [15:0] m_tdata;
    logic [2:0]  m_tuser;
    logic        m_tready;
    logic        win_done;
    logic        busy;
    logic        done;
    logic [15:0] win_sent;
    logic [1:0]  inflight;
    logic        err;

    int errors = 0;
    int checks = 0;

    window_sequencer #(
        .PAR_DATA_WIDTH(16),
        .PAR_WINDOW_LEN(8),
        .PAR_MAX_INFLIGHT(2),
        .PAR_CNT_WIDTH(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_num_windows(num_windows),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .i_win_done(win_done), .o_busy(busy), .o_done(done),
        .o_win_sent(win_sent), .o_inflight(inflight), .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; win_done = 1'b0;
        s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = 16'd0; num_windows = 16'd0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] n);
        num_windows = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({busy, done, m_tvalid, m_tlast, s_tready, err} !== 6'b0 || m_tuser !== 3'd0 ||
            win_sent !== 16'd0 || inflight !== 2'd0 || m_tdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b tvalid=%0b tuser=%0d sent=%0d infl=%0d expected all 0",
                     busy, done, m_tvalid, m_tuser, win_sent, inflight);
        end
    endtask

    // num=3, flow always on; completions 10 cycles after each tlast (c7, c15, c25).
    task automatic test_basic_windows();
        logic       exp_beat;
        logic [2:0] exp_user;
        do_reset();
        s_tvalid = 1'b1; m_tready = 1'b1;
        do_start(16'd3);
        for (int c = 0; c < 39; c++) begin
            s_tdata  = 16'(c + 100);
            win_done = (c == 17 || c == 25 || c == 35);
            #1;
            exp_beat = (c <= 15) || (c >= 18 && c <= 25);
            exp_user = (c <= 15) ? 3'(c % 8) : ((c >= 18 && c <= 25) ? 3'(c - 18) : 3'd0);
            checks++;
            if (m_tvalid !== exp_beat) begin
                errors++;
                $display("FAIL basic_tvalid c=%0d: got %0b want %0b", c, m_tvalid, exp_beat);
            end
            if (exp_beat) begin
                checks++;
                if (m_tuser !== exp_user || m_tlast !== (exp_user == 3'd7) || m_tdata !== 16'(c + 100)) begin
                    errors++;
                    $display("FAIL basic_beat c=%0d: tuser=%0d tlast=%0b tdata=%0d want %0d %0b %0d",
                             c, m_tuser, m_tlast, m_tdata, exp_user, exp_user == 3'd7, c + 100);
                end
            end
            if (c == 16) begin
                checks++;
                if (inflight !== 2'd2 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_stall_inflight: got %0d want 2", inflight);
                end
            end
            if (c == 26) begin
                checks++;
                if (inflight !== 2'd1 || win_sent !== 16'd3) begin
                    errors++;
                    $display("FAIL basic_coincident: inflight=%0d sent=%0d want 1 3", inflight, win_sent);
                end
            end
            if (c >= 35) begin
                checks++;
                if (done !== (c == 36) || busy !== (c < 36)) begin
                    errors++;
                    $display("FAIL basic_done c=%0d: done=%0b busy=%0b want %0b %0b",
                             c, done, busy, c == 36, c < 36);
                end
            end
            tick();
        end
        win_done = 1'b0;
    endtask

    // Continuous run with m_ready toggling every cycle.
    task automatic test_backpressure();
        logic [2:0] exp_idx = 3'd0;
        do_reset();
        s_tvalid = 1'b1;
        do_start(16'd0);
        for (int c = 0; c < 20; c++) begin
            m_tready = c[0];
            #1;
            checks++;
            if (s_tready !== m_tready || m_tvalid !== 1'b1 || m_tuser !== exp_idx) begin
                errors++;
                $display("FAIL bp c=%0d: tready=%0b tuser=%0d want %0b %0d", c, s_tready, m_tuser, m_tready, exp_idx);
            end
            if (m_tready) exp_idx = exp_idx + 3'd1;
            tick();
        end
        checks++;
        if (win_sent !== 16'd1 || inflight !== 2'd1) begin
            errors++;
            $display("FAIL bp_counts: sent=%0d infl=%0d want 1 1", win_sent, inflight);
        end
    endtask

    // Stop requested mid-window: window finishes, nothing more is issued.
    task automatic test_stop_mid_window();
        do_reset();
        s_tvalid = 1'b1; m_tready = 1'b1;
        do_start(16'd0);
        for (int c = 0; c < 13; c++) begin
            stop     = (c == 3);
            win_done = (c == 10);
            #1;
            checks++;
            if (m_tvalid !== (c <= 7) || (c <= 7 && m_tuser !== 3'(c))) begin
                errors++;
                $display("FAIL stop_beat c=%0d: tvalid=%0b tuser=%0d want %0b %0d", c, m_tvalid, m_tuser, c <= 7, c);
            end
            if (c >= 8) begin
                checks++;
                if (done !== (c == 11) || busy !== (c < 11) || win_sent !== 16'd1) begin
                    errors++;
                    $display("FAIL stop_drain c=%0d: done=%0b busy=%0b sent=%0d want %0b %0b 1",
                             c, done, busy, win_sent, c == 11, c < 11);
                end
            end
            tick();
        end
        stop = 1'b0; win_done = 1'b0;
    endtask

    // Stop at a boundary with no beat goes straight to drain and finishes.
    task automatic test_stop_idle_boundary();
        do_reset();
        s_tvalid = 1'b0; m_tready = 1'b1;
        do_start(16'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || win_sent !== 16'd0) begin
            errors++;
            $display("FAIL stop_boundary: done=%0b busy=%0b sent=%0d want 1 0 0", done, busy, win_sent);
        end
    endtask

    // Completion coincident with tlast at inflight=1 must not stall.
    task automatic test_back_to_back();
        do_reset();
        s_tvalid = 1'b1; m_tready = 1'b1;
        do_start(16'd0);
        for (int c = 0; c < 17; c++) begin
            win_done = (c == 15);
            #1;
            if (c == 16) begin
                checks++;
                if (inflight !== 2'd1 || m_tvalid !== 1'b1 || m_tuser !== 3'd0) begin
                    errors++;
                    $display("FAIL b2b: inflight=%0d tvalid=%0b tuser=%0d want 1 1 0", inflight, m_tvalid, m_tuser);
                end
            end
            tick();
        end
        win_done = 1'b0;
    endtask

    task automatic test_spurious_done();
        do_reset();
        win_done = 1'b1;
        tick();
        win_done = 1'b0;
        checks++;
        if (err !== 1'b1 || inflight !== 2'd0) begin
            errors++;
            $display("FAIL spurious_err: err=%0b infl=%0d want 1 0", err, inflight);
        end
        tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL spurious_sticky: err=%0b want 1", err);
        end
    endtask

    // Async reset mid-window, then a fresh run restarts at index 0.
    task automatic test_reset_mid_window();
        do_reset();
        s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 16'h55AA;
        do_start(16'd0);
        tick(); tick(); tick(); tick(); tick();
        checks++;
        if (m_tuser !== 3'd5) begin
            errors++;
            $display("FAIL rst_pre: tuser=%0d want 5", m_tuser);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, m_tvalid, m_tlast, s_tready} !== 4'b0 || m_tuser !== 3'd0 || m_tdata !== 16'd0) begin
            errors++;
            $display("FAIL rst_async: busy=%0b tvalid=%0b tuser=%0d tdata=%0d want 0", busy, m_tvalid, m_tuser, m_tdata);
        end
        tick();
        rst = 1'b0;
        do_start(16'd0);
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tuser !== 3'd0 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: tvalid=%0b tuser=%0d want 1 0", m_tvalid, m_tuser);
        end
    endtask

    initial begin
        test_reset();
        test_basic_windows();
        test_backpressure();
        test_stop_mid_window();
        test_stop_idle_boundary();
        test_back_to_back();
        test_spurious_done();
        test_reset_mid_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_sequencer.md
Name: window_sequencer

Overview:
- Sequences a raw, unframed sample stream into fixed-length windows for the mean-removal (centralize) stage.
- Generates the per-sample window index (tuser) and end-of-window marker (tlast) that the downstream stage requires.
- Limits windows in flight using completion pulses fed back from downstream.
- Supports a programmed window count or continuous run, with a graceful stop at a window boundary.

Parameters:
PAR_DATA_WIDTH, 16, sample width (signed)
PAR_WINDOW_LEN, 128, samples per window, >=2
PAR_USER_WIDTH, ceil(log2(PAR_WINDOW_LEN)), index width
PAR_MAX_INFLIGHT, 2, max windows issued but not completed, >=1
PAR_CNT_WIDTH, 16, window counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_start  in  1  start pulse, accepted only in IDLE
i_stop  in  1  stop request pulse
i_num_windows  in  PAR_CNT_WIDTH  windows to issue, 0 = continuous; sampled on accepted i_start
s_axis_tvalid  in  1  raw sample valid
s_axis_tdata  in  PAR_DATA_WIDTH  raw sample
s_axis_tready  out  1  raw sample ready
m_axis_tvalid  out  1  to centralize
m_axis_tlast  out  1  last sample of window
m_axis_tdata  out  PAR_DATA_WIDTH  sample
m_axis_tuser  out  PAR_USER_WIDTH  index in window
m_axis_tready  in  1  downstream ready
i_win_done  in  1  one-cycle pulse per window completed downstream
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse on return to IDLE
o_win_sent  out  PAR_CNT_WIDTH  windows issued this run
o_inflight  out  log2(PAR_MAX_INFLIGHT+1)  current in-flight count
o_err  out  1  sticky: i_win_done received with inflight==0

Behaviour:
Reset (async, i_rst=1):
- State IDLE.
- All outputs 0; idx, counters and o_err cleared.
- Reset mid-window drops the partial window; no tlast is emitted.

Datapath:
- Combinational pass-through, zero latency.
- m_axis_tvalid = s_axis_tvalid & run; s_axis_tready = m_axis_tready & run; run = (state==RUN).
- m_axis_tdata = s_axis_tdata; m_axis_tuser = idx; m_axis_tlast = (idx==PAR_WINDOW_LEN-1).
- Beat = m_axis_tvalid & m_axis_tready. On a beat, idx increments, wrapping to 0 after LEN-1.

Window end (last beat):
- o_win_sent += 1.
- inflight += 1, net of a same-cycle i_win_done.

Inflight:
- i_win_done decrements inflight when inflight>0; otherwise it is ignored and sets o_err.
- A simultaneous increment and decrement leaves inflight unchanged.

FSM:
- IDLE: on i_start, latch i_num_windows, clear idx, o_win_sent, stop_pend -> RUN. i_stop in IDLE is ignored.
- RUN, last beat: evaluated in priority order.
  - If (num!=0 and o_win_sent+1==num) or stop_pend or i_stop -> DRAIN.
  - Else if inflight_next==PAR_MAX_INFLIGHT -> STALL.
  - Else stay in RUN.
- RUN, i_stop: if idx==0 and no beat this cycle -> DRAIN. Otherwise set stop_pend and finish the current window. No partial windows are ever emitted.
- STALL: no beats. i_stop sets stop_pend.
  - If inflight_next<MAX: go to DRAIN if stop_pend, else RUN.
  - A i_win_done arriving the same cycle as entry into STALL is counted; the exit is taken the next cycle.
- DRAIN: no beats. When inflight==0 -> IDLE and pulse o_done.
- o_win_sent rolls over at 2^PAR_CNT_WIDTH in continuous mode.
- i_start outside IDLE is ignored.

Test Plan:
- LEN=8, MAX=2, num=3, s_valid and m_ready held 1; i_win_done pulsed 10 cycles after each tlast.
  -> tuser 0..7 x3, tlast on tuser=7; STALL after window 2 until first done; o_done 1 cycle after third done; o_win_sent=3.
- LEN=8, num=0, m_ready toggled 50%.
  -> no beat while m_ready=0; tuser contiguous; s_tready mirrors m_ready in RUN.
- i_stop at tuser=3 of window 1.
  -> window 1 completes through tuser=7; window 2 is never issued; DRAIN until inflight=0; o_win_sent=1.
- i_win_done coincident with a tlast at inflight=1, MAX=2.
  -> inflight stays 1; no STALL.
- Spurious i_win_done in IDLE.
  -> o_err=1 and sticky; inflight stays 0.
- Assert i_rst at tuser=5.
  -> all outputs 0 immediately; after release and i_start, the first beat has tuser=0.
